// File: rtl/seq_gen_pkg.sv
// Shared state encoding and helpers for the seq_gen serial pattern transmitter.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Level driven on B whenever no pattern bit is valid.
   localparam logic IDLE_LVL = 1'b0;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, shift-left register; the bit presented is the one at position len_i-1,
// so a pattern of any length up to MAX_LEN is emitted MSB-first.
module seq_piso #(
   parameter int MAX_LEN = 8,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               Clk,
   input  logic               load_i,
   input  logic               shift_i,
   input  logic [MAX_LEN-1:0] data_i,
   input  logic [LW-1:0]      len_i,
   output logic               msb_o
);

   logic [MAX_LEN-1:0] shreg_q;
   logic [MAX_LEN-1:0] shreg_d;
   logic [LW-1:0]      idx;
   logic [MAX_LEN-1:0] sel_mask;

   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = data_i;
      end else if (shift_i) begin
         shreg_d = shreg_q << 1;
      end
   end

   // Pure data path: content is only observed while the controller is in SHIFT.
   always_ff @(posedge Clk) begin
      shreg_q <= shreg_d;
   end

   // Mask-based select keeps the read well defined for every len_i value.
   always_comb begin
      idx      = len_i - LW'(1);
      sel_mask = MAX_LEN'(1) << idx;
      msb_o    = |(shreg_q & sel_mask);
   end

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: emits a latched pattern MSB-first, repeated Reps times
// with Gap idle cycles between repetitions, then pulses Done.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = $clog2(MAX_LEN + 1),
   parameter int RW      = 8,
   parameter int GW      = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Abort,
   input  logic [MAX_LEN-1:0] Pattern,
   input  logic [LW-1:0]      Len,
   input  logic [RW-1:0]      Reps,
   input  logic [GW-1:0]      Gap,
   output logic               B,
   output logic               B_vld,
   output logic               Busy,
   output logic               Done
);

   state_e             state_q, state_d;
   logic [LW-1:0]      bcnt_q, bcnt_d;
   logic [RW-1:0]      rcnt_q, rcnt_d;
   logic [GW-1:0]      gcnt_q, gcnt_d;
   logic [LW-1:0]      len_q, len_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;

   logic [LW-1:0]      len_clamped;
   logic               piso_load;
   logic               piso_shift;
   logic [MAX_LEN-1:0] piso_data;
   logic               piso_bit;

   assign len_clamped = LW'(clamp_len(32'(Len), MAX_LEN));

   // The initial load comes straight from the port; reloads use the latched copy.
   assign piso_data = (state_q == IDLE) ? Pattern : pat_q;

   seq_piso #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_piso (
      .Clk     (Clk),
      .load_i  (piso_load),
      .shift_i (piso_shift),
      .data_i  (piso_data),
      .len_i   (len_q),
      .msb_o   (piso_bit)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         bcnt_q <= '0;
         rcnt_q <= '0;
         gcnt_q <= '0;
         len_q  <= '0;
         gap_q  <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         rcnt_q <= rcnt_d;
         gcnt_q <= gcnt_d;
         len_q  <= len_d;
         gap_q  <= gap_d;
      end
   end

   always_ff @(posedge Clk) begin
      pat_q <= pat_d;
   end

   // rcnt_q holds the repetitions still owed, including the one being shifted.
   always_comb begin
      state_d    = state_q;
      bcnt_d     = bcnt_q;
      rcnt_d     = rcnt_q;
      gcnt_d     = gcnt_q;
      len_d      = len_q;
      gap_d      = gap_q;
      pat_d      = pat_q;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               pat_d     = Pattern;
               len_d     = len_clamped;
               gap_d     = Gap;
               piso_load = 1'b1;
               if ((len_clamped == '0) || (Reps == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
                  bcnt_d  = len_clamped;
                  rcnt_d  = Reps;
               end
            end
         end
         SHIFT: begin
            if (Abort) begin
               state_d = IDLE;
               bcnt_d  = '0;
               rcnt_d  = '0;
               gcnt_d  = '0;
            end else if (bcnt_q == LW'(1)) begin
               if (rcnt_q > RW'(1)) begin
                  rcnt_d = rcnt_q - RW'(1);
                  if (gap_q != '0) begin
                     state_d = GAP;
                     bcnt_d  = '0;
                     gcnt_d  = gap_q;
                  end else begin
                     piso_load = 1'b1;
                     bcnt_d    = len_q;
                  end
               end else begin
                  state_d = DONE;
                  bcnt_d  = '0;
                  rcnt_d  = '0;
               end
            end else begin
               piso_shift = 1'b1;
               bcnt_d     = bcnt_q - LW'(1);
            end
         end
         GAP: begin
            if (Abort) begin
               state_d = IDLE;
               bcnt_d  = '0;
               rcnt_d  = '0;
               gcnt_d  = '0;
            end else if (gcnt_q == GW'(1)) begin
               state_d   = SHIFT;
               gcnt_d    = '0;
               piso_load = 1'b1;
               bcnt_d    = len_q;
            end else begin
               gcnt_d = gcnt_q - GW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      B_vld = (state_q == SHIFT);
      B     = B_vld ? piso_bit : IDLE_LVL;
      Busy  = (state_q == SHIFT) || (state_q == GAP);
      Done  = (state_q == DONE);
   end

   a_idle_level : assert property (@(posedge Clk) disable iff (Rst) !B_vld |-> (B == IDLE_LVL));
   a_done_pulse : assert property (@(posedge Clk) disable iff (Rst) Done |=> !Done);
   a_done_idle  : assert property (@(posedge Clk) disable iff (Rst) !(Busy && Done));

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a stream model expands each accepted request into the
// per-cycle output sequence it should produce; a monitor compares every cycle.
module tb_seq_gen;

   localparam int MAX_LEN = 8;
   localparam int LW      = $clog2(MAX_LEN + 1);
   localparam int RW      = 8;
   localparam int GW      = 4;

   logic               Clk = 1'b0;
   logic               Rst;
   logic               Start;
   logic               Abort;
   logic [MAX_LEN-1:0] Pattern;
   logic [LW-1:0]      Len;
   logic [RW-1:0]      Reps;
   logic [GW-1:0]      Gap;
   logic               B;
   logic               B_vld;
   logic               Busy;
   logic               Done;

   typedef struct packed {
      logic b;
      logic vld;
      logic busy;
      logic done;
   } obs_t;

   obs_t  pend_q[$];
   obs_t  sb_q[$];
   obs_t  cur = '0;
   int    checks = 0;
   int    passed = 0;
   int    cyc = 0;
   string phase = "reset";

   always #5 Clk = ~Clk;

   seq_gen #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW),
      .RW      (RW),
      .GW      (GW)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .Start   (Start),
      .Abort   (Abort),
      .Pattern (Pattern),
      .Len     (Len),
      .Reps    (Reps),
      .Gap     (Gap),
      .B       (B),
      .B_vld   (B_vld),
      .Busy    (Busy),
      .Done    (Done)
   );

   // Whole transmission as a list of cycles: Reps copies of the pattern, gaps between, Done.
   function automatic void expand(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                                  input logic [RW-1:0] reps, input logic [GW-1:0] gap);
      int l;
      l = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      if (l == 0 || reps == 0) begin
         pend_q.push_back(4'b0001);
         return;
      end
      for (int r = 0; r < int'(reps); r++) begin
         for (int i = l - 1; i >= 0; i--) pend_q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
         if (r < int'(reps) - 1)
            for (int k = 0; k < int'(gap); k++) pend_q.push_back(4'b0010);
      end
      pend_q.push_back(4'b0001);
   endfunction

   always @(posedge Clk) begin : model
      cyc++;
      if (Rst) begin
         pend_q.delete();
      end else if (cur.busy && Abort) begin
         pend_q.delete();
      end else if (pend_q.size() == 0 && cur == '0 && Start) begin
         expand(Pattern, Len, Reps, Gap);
      end
      if (pend_q.size() != 0) cur = pend_q.pop_front();
      else                    cur = '0;
      sb_q.push_back(cur);
   end

   always @(negedge Clk) begin : monitor
      obs_t exp_o;
      obs_t act_o;
      act_o = {B, B_vld, Busy, Done};
      checks++;
      if (sb_q.size() == 0) begin
         $display("FAIL %s cyc %0d: outputs %b seen with no expectation queued", phase, cyc, act_o);
      end else begin
         exp_o = sb_q.pop_front();
         if (act_o === exp_o) passed++;
         else $display("FAIL %s cyc %0d: {B,B_vld,Busy,Done} got %b expected %b",
                       phase, cyc, act_o, exp_o);
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic send(input logic [MAX_LEN-1:0] p, input int l, input int r, input int g);
      Pattern = p;
      Len     = LW'(l);
      Reps    = RW'(r);
      Gap     = GW'(g);
      Start   = 1'b1;
      tick();
      Start   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(pend_q.size() == 0 && cur == '0) && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) begin
         checks++;
         $display("FAIL %s drain: still busy after %0d cycles, required idle", phase, n);
      end
      repeat (2) tick();
   endtask

   initial begin
      Rst = 1'b1; Start = 1'b0; Abort = 1'b0;
      Pattern = '0; Len = '0; Reps = '0; Gap = '0;
      repeat (3) tick();
      Rst = 1'b0;
      tick();

      phase = "single";     send(8'b0000_1101, 4, 1, 0); drain();
      phase = "rep_gap";    send(8'b0000_1101, 4, 2, 2); drain();
      phase = "rep_nogap";  send(8'b0000_1011, 3, 3, 0); drain();
      phase = "len0";       send(8'hFF, 0, 3, 1);         drain();
      phase = "reps0";      send(8'hFF, 5, 0, 1);         drain();
      phase = "clamp";      send(8'hA5, 15, 1, 0);        drain();
      phase = "maxreps";    send(8'h01, 1, 255, 0);       drain();

      phase = "restart";
      send(8'b0000_1101, 4, 1, 0);
      tick();
      Pattern = 8'hFF; Len = LW'(8); Reps = RW'(2); Start = 1'b1;
      tick();
      Start = 1'b0;
      drain();

      phase = "rst_mid";
      send(8'b0000_1101, 4, 1, 0);
      tick();
      Rst = 1'b1; tick(); Rst = 1'b0;
      drain();
      send(8'b0000_1101, 4, 1, 0); drain();

      phase = "abort_mid";
      send(8'b0000_1101, 4, 2, 3);
      repeat (2) tick();
      Abort = 1'b1; tick(); Abort = 1'b0;
      drain();
      send(8'h96, 8, 1, 0); drain();

      phase = "abort_gap";
      send(8'h03, 2, 2, 4);
      repeat (3) tick();
      Abort = 1'b1; tick(); Abort = 1'b0;
      drain();

      phase = "start_abort_idle";
      Abort = 1'b1;
      send(8'h05, 3, 1, 0);
      Abort = 1'b0;
      drain();

      phase = "abort_done";
      send(8'h00, 0, 1, 0);
      Abort = 1'b1; Start = 1'b1; tick();
      Abort = 1'b0; Start = 1'b0;
      drain();

      phase = "random";
      for (int c = 0; c < 3000; c++) begin
         Rst     = ($urandom_range(0, 199) == 0);
         Start   = ($urandom_range(0, 5) == 0);
         Abort   = ($urandom_range(0, 39) == 0);
         Pattern = MAX_LEN'($urandom);
         Len     = LW'($urandom_range(0, 15));
         Reps    = RW'($urandom_range(0, 3));
         Gap     = GW'($urandom_range(0, 3));
         tick();
      end
      Rst = 1'b0; Start = 1'b0; Abort = 1'b0;
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial bit-pattern transmitter: the sending end of the serial sequence-detector interface. It drives the single-bit B line that a detector samples once per Clk.
- Loads a programmable pattern, then emits it MSB-first, one bit per clock.
- Supports a repeat count and an idle gap between repetitions.
- Used as a stimulus/traffic source for detector blocks and as a standalone serial pattern source.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- LW, $clog2(MAX_LEN+1): width of the Len field.
- RW, 8: width of the repeat-count field.
- GW, 4: width of the gap-length field.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request to begin transmission; honoured only in IDLE.
- Abort  input  1  terminate current transmission.
- Pattern  input  MAX_LEN  pattern bits; bit Len-1 is sent first.
- Len  input  LW  number of pattern bits to send.
- Reps  input  RW  number of pattern repetitions.
- Gap  input  GW  idle cycles inserted between repetitions.
- B  output  1  serial data bit.
- B_vld  output  1  B carries a pattern bit this cycle.
- Busy  output  1  transmission in progress.
- Done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high (Rst).
- Reset values: all outputs 0 (B=0, B_vld=0, Busy=0, Done=0); state=IDLE; all counters 0.
- Rst has priority over every other input, including mid-transmission. Outputs read 0 from the edge at which Rst=1 is sampled.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Start=1 at an edge latches Pattern, Len, Reps and Gap.
  - Len>MAX_LEN is clamped to MAX_LEN.
  - If latched Len==0 or Reps==0, go to DONE; no bits are sent.
  - Otherwise go to SHIFT. Busy=1 and the first bit (Pattern[Len-1]) appear on B with B_vld=1 in the cycle after the Start edge. Latency is 1 cycle.
- SHIFT:
  - One bit per cycle, MSB-first: Pattern[Len-1] down to Pattern[0]. B_vld=1 for exactly Len consecutive cycles per repetition.
  - After the last bit of a repetition:
    - If repetitions remain and Gap>0, go to GAP.
    - If repetitions remain and Gap==0, reload and continue in SHIFT with no bubble.
    - Otherwise go to DONE.
- GAP: B=0, B_vld=0, Busy=1 for exactly Gap cycles, then SHIFT with the pattern reloaded from the latched copy.
- DONE: Done=1, Busy=0, B=0, B_vld=0 for one cycle, then IDLE unconditionally.
- B=0 whenever B_vld=0.
- Start while Busy=1 or in DONE is ignored. Pattern, Len, Reps and Gap changes after latching have no effect.
- Abort=1 in SHIFT or GAP: IDLE at the next edge with all outputs 0; no Done pulse. Abort in IDLE or DONE is ignored. Start and Abort together in IDLE: Start wins.
- Counters:
  - Bit counter: LW bits, counts down.
  - Repetition counter: RW bits, counts down; no wrap-around. Reps=2^RW-1 yields exactly that many repetitions.
  - Gap counter: GW bits.
- Total Busy cycles = Reps*Len + (Reps-1)*Gap.

Decomposition:
- Package seq_gen_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3.
  - IDLE_LVL=1'b0 (the line level when no bit is valid).
- Sub-module seq_piso: MAX_LEN-bit parallel-load, shift-left register with a load and shift enable. Its MSB-side output is indexed by the latched Len.
- seq_gen holds the FSM and the three counters.

Test Plan:
- Pattern=8'b0000_1101, Len=4, Reps=1, Gap=0, Start pulse at cycle 0 → B=1,1,0,1 with B_vld=1 at cycles 1–4; Done=1 at cycle 5; Busy=1 at cycles 1–4 only.
- Same pattern with Reps=2, Gap=2 → cycles 1–4 B=1101; cycles 5–6 B_vld=0; cycles 7–10 B=1101; Done at cycle 11.
- Len=0 (or Reps=0) → Done at cycle 1; B_vld never asserted; Busy stays 0.
- Start re-asserted at cycle 2 with a different Pattern during the first test → output unchanged from the first test; no second transmission.
- Rst=1 sampled at cycle 2 of the first test → B, B_vld, Busy = 0 from cycle 2; no Done. Abort sampled at cycle 3 → same response, IDLE. A new Start afterwards transmits normally.
- Len=15 with MAX_LEN=8, Pattern=8'hA5, Reps=1 → exactly 8 bits 1,0,1,0,0,1,0,1; Done at cycle 9.
